crypto_mmio_xbar: RTL and testbench

Single-master to multi-slave MMIO router between the CPU data bus and the crypto accelerator register windows: AES-GCM at 0x4000_0000, Ed25519/SHAKE at 0x4000_1000, BIKE at 0x4000_2000, RSA at 0x4000_3000. It decodes each CPU access to a 4 KB slot and issues exactly one single-cycle `valid` pulse to that slave. It waits for the slave's one-cycle `ready`, then returns data or an error to the CPU. Unmapped and hung accesses are terminated cleanly.

---
 rtl/crypto_mmio_pkg.sv | 37 +++
 rtl/crypto_mmio_xbar_timeout.sv | 39 +++
 rtl/crypto_mmio_xbar.sv | 183 ++++++++++++++++++
 tb/tb_crypto_mmio_xbar.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_mmio_pkg.sv
// Shared definitions for the crypto MMIO crossbar: per-core register window
// bases, the slot index enum and the crossbar FSM state type.
package crypto_mmio_pkg;

   localparam logic [31:0] AES_GCM_BASE = 32'h4000_0000;
   localparam logic [31:0] ED25519_BASE = 32'h4000_1000;
   localparam logic [31:0] BIKE_BASE    = 32'h4000_2000;
   localparam logic [31:0] RSA_BASE     = 32'h4000_3000;

   // Each slave window is 4 KB
   localparam int unsigned SLOT_SIZE_LOG2 = 12;

   typedef enum logic [1:0] {
      SLOT_AES_GCM = 2'd0,
      SLOT_ED25519 = 2'd1,
      SLOT_BIKE    = 2'd2,
      SLOT_RSA     = 2'd3
   } slot_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } xbar_state_t;

   // Base address of a given core's register window
   function automatic logic [31:0] slot_base(input slot_idx_t s);
      case (s)
         SLOT_AES_GCM: slot_base = AES_GCM_BASE;
         SLOT_ED25519: slot_base = ED25519_BASE;
         SLOT_BIKE:    slot_base = BIKE_BASE;
         default:      slot_base = RSA_BASE;
      endcase
   endfunction

endpackage

// File: rtl/crypto_mmio_xbar_timeout.sv
// mmio_timeout_ctr: saturating cycle counter with synchronous clear and an
// expire flag raised when the count reaches LIMIT-1. Used by crypto_mmio_xbar
// only when CRYPTO_XBAR_TIMEOUT_EN is defined.
module mmio_timeout_ctr #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic inc_i,
   output logic expired_o
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: clear wins, otherwise count up and stick at LIMIT
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != CW'(LIMIT))) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/crypto_mmio_xbar.sv
// crypto_mmio_xbar: single-master to N_SLOTS-slave MMIO router for the crypto
// accelerator windows. Each CPU access is decoded to a 4 KB slot, forwarded as
// a one-cycle s_valid pulse, and answered on m_ready/m_err once the selected
// slave acks. Unmapped accesses return ERR_RDATA with m_err.
// Optional feature macro: CRYPTO_XBAR_TIMEOUT_EN adds a WAIT timeout that
// terminates hung accesses with an error after TIMEOUT_CYCLES cycles.
module crypto_mmio_xbar
   import crypto_mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR      = AES_GCM_BASE,
   parameter int unsigned N_SLOTS        = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [31:0]           m_addr,
   input  logic [31:0]           m_wdata,
   input  logic                  m_we,
   input  logic                  m_valid,
   output logic [31:0]           m_rdata,
   output logic                  m_ready,
   output logic                  m_err,
   output logic [31:0]           s_addr,
   output logic [31:0]           s_wdata,
   output logic                  s_we,
   output logic [N_SLOTS-1:0]    s_valid,
   input  logic [32*N_SLOTS-1:0] s_rdata,
   input  logic [N_SLOTS-1:0]    s_ready
);

   localparam int unsigned SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam int unsigned HI     = SLOT_SIZE_LOG2 + $clog2(N_SLOTS);
   localparam logic [N_SLOTS-1:0] SV_ONE = N_SLOTS'(1);

   // Elaboration-time parameter sanity
   if (N_SLOTS < 1 || N_SLOTS > 16 || (N_SLOTS & (N_SLOTS - 1)) != 0) begin : g_bad_slots
      $error("crypto_mmio_xbar: N_SLOTS must be a power of two in 1..16");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
      $error("crypto_mmio_xbar: TIMEOUT_CYCLES must be in 1..65535");
   end
   if ((BASE_ADDR & ((32'(N_SLOTS) << SLOT_SIZE_LOG2) - 32'd1)) != 32'd0) begin : g_bad_base
      $error("crypto_mmio_xbar: BASE_ADDR not aligned to the crossbar region size");
   end

   xbar_state_t         state_q, state_d;
   logic [31:0]         s_addr_q, s_addr_d;
   logic [31:0]         s_wdata_q, s_wdata_d;
   logic                s_we_q, s_we_d;
   logic [N_SLOTS-1:0]  s_valid_q, s_valid_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic                m_ready_q, m_ready_d;
   logic                m_err_q, m_err_d;
   logic [31:0]         m_rdata_q, m_rdata_d;

   // Address decode of the live CPU request
   logic [19:0]       page;
   logic              region_hit;
   logic [SLOT_W-1:0] slot_sel;

   assign page       = m_addr[31:SLOT_SIZE_LOG2];
   assign region_hit = ((m_addr >> HI) == (BASE_ADDR >> HI));
   assign slot_sel   = SLOT_W'(page & 20'(N_SLOTS - 1));

   // Only the slave that owns the latched access can answer it
   logic        slave_rdy;
   logic [31:0] slave_rdata;

   assign slave_rdy   = s_ready[slot_q];
   assign slave_rdata = s_rdata[32*slot_q +: 32];

   logic tmo_expired;

`ifdef CRYPTO_XBAR_TIMEOUT_EN
   logic tmo_clr;
   logic tmo_inc;

   assign tmo_clr = (state_q == ISSUE);
   assign tmo_inc = (state_q == WAIT) && !slave_rdy;

   mmio_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (tmo_clr),
      .inc_i     (tmo_inc),
      .expired_o (tmo_expired)
   );
`else
   // Without the timeout a WAIT lasts until the slave answers
   assign tmo_expired = 1'b0;
`endif

   // Next-state and registered-output logic; strobes default low every cycle
   always_comb begin
      state_d   = state_q;
      s_addr_d  = s_addr_q;
      s_wdata_d = s_wdata_q;
      s_we_d    = s_we_q;
      slot_d    = slot_q;
      s_valid_d = '0;
      m_ready_d = 1'b0;
      m_err_d   = 1'b0;
      m_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (m_valid) begin
               if (region_hit) begin
                  s_addr_d  = m_addr;
                  s_wdata_d = m_wdata;
                  s_we_d    = m_we;
                  slot_d    = slot_sel;
                  s_valid_d = SV_ONE << slot_sel;
                  state_d   = ISSUE;
               end else begin
                  m_ready_d = 1'b1;
                  m_err_d   = 1'b1;
                  m_rdata_d = ERR_RDATA;
                  state_d   = RESP;
               end
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (slave_rdy) begin
               m_ready_d = 1'b1;
               m_rdata_d = s_we_q ? 32'h0 : slave_rdata;
               state_d   = RESP;
            end else if (tmo_expired) begin
               m_ready_d = 1'b1;
               m_err_d   = 1'b1;
               m_rdata_d = ERR_RDATA;
               state_d   = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_we_q    <= 1'b0;
         slot_q    <= '0;
         s_valid_q <= '0;
         m_ready_q <= 1'b0;
         m_err_q   <= 1'b0;
         m_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         s_we_q    <= s_we_d;
         slot_q    <= slot_d;
         s_valid_q <= s_valid_d;
         m_ready_q <= m_ready_d;
         m_err_q   <= m_err_d;
         m_rdata_q <= m_rdata_d;
      end
   end

   assign s_addr  = s_addr_q;
   assign s_wdata = s_wdata_q;
   assign s_we    = s_we_q;
   assign s_valid = s_valid_q;
   assign m_ready = m_ready_q;
   assign m_err   = m_err_q;
   assign m_rdata = m_rdata_q;

endmodule

// File: tb/tb_crypto_mmio_xbar.sv
// Scoreboard bench for crypto_mmio_xbar: directed accesses push expected
// slave requests and CPU responses into queues; a monitor pops and compares
// whenever s_valid or m_ready is seen. A behavioural slave acks after a
// per-slot delay (0 = never).
module tb_crypto_mmio_xbar;

   localparam int NS  = 4;
   localparam int TMO = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [31:0]       m_addr = '0;
   logic [31:0]       m_wdata = '0;
   logic              m_we = 1'b0;
   logic              m_valid = 1'b0;
   logic [31:0]       m_rdata;
   logic              m_ready;
   logic              m_err;
   logic [31:0]       s_addr;
   logic [31:0]       s_wdata;
   logic              s_we;
   logic [NS-1:0]     s_valid;
   logic [32*NS-1:0]  s_rdata = '0;
   logic [NS-1:0]     s_ready = '0;

   crypto_mmio_xbar #(
      .BASE_ADDR      (32'h4000_0000),
      .N_SLOTS        (NS),
      .TIMEOUT_CYCLES (TMO),
      .ERR_RDATA      (32'hDEAD_BEEF)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_we    (m_we),
      .m_valid (m_valid),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .m_err   (m_err),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_we    (s_we),
      .s_valid (s_valid),
      .s_rdata (s_rdata),
      .s_ready (s_ready)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          due;
      logic [31:0] addr;
      logic        we;
      bit          mapped;
   } resp_t;

   typedef struct {
      logic [NS-1:0] mask;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic          we;
   } sreq_t;

   resp_t         rq[$];
   sreq_t         sq[$];
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   int            last_resp_cyc = -10;
   int            ack_dly[NS];
   int            inj_at_cyc = -1;
   logic [NS-1:0] inj_mask = '0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural slaves: ack ack_dly[i] cycles after s_valid, plus optional stray pulse
   initial begin : slave_model
      int            cnt[NS];
      logic [NS-1:0] nxt;
      for (int i = 0; i < NS; i++) cnt[i] = 0;
      forever begin
         @(negedge clk);
         nxt = '0;
         for (int i = 0; i < NS; i++) begin
            if (cnt[i] > 0) begin
               cnt[i]--;
               if (cnt[i] == 0) nxt[i] = 1'b1;
            end
            if (s_valid[i] === 1'b1 && ack_dly[i] > 0) cnt[i] = ack_dly[i];
         end
         if (cyc == inj_at_cyc) nxt = nxt | inj_mask;
         s_ready = nxt;
      end
   end

   // Monitor: compares every slave request and CPU response against the queues
   initial begin : monitor
      resp_t r;
      sreq_t s;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (m_ready === 1'b1) begin
               if (rq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_m_ready: got m_ready=1 at cycle %0d, expected no response", cyc);
               end else begin
                  r = rq.pop_front();
                  chk("m_err", 32'(m_err), 32'(r.err));
                  chk("m_rdata", m_rdata, r.rdata);
                  chk("resp_cycle", 32'(cyc), 32'(r.due));
                  if (r.mapped) begin
                     chk("s_addr_hold", s_addr, r.addr);
                     chk("s_we_hold", 32'(s_we), 32'(r.we));
                  end
               end
            end else begin
               chk("m_rdata_idle", m_rdata, 32'h0);
               chk("m_err_idle", 32'(m_err), 32'h0);
            end
            if (s_valid !== '0) begin
               if (sq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_s_valid: got s_valid=0x%0h at cycle %0d, expected none", s_valid, cyc);
               end else begin
                  s = sq.pop_front();
                  chk("s_valid_mask", 32'(s_valid), 32'(s.mask));
                  chk("s_addr", s_addr, s.addr);
                  chk("s_wdata", s_wdata, s.wdata);
                  chk("s_we", 32'(s_we), 32'(s.we));
               end
            end
         end
      end
   end

   // One CPU access: queue expectations, drive, wait (bounded) for m_ready
   task automatic do_access(input logic [31:0] a, input logic [31:0] wd, input logic we,
                            input logic [NS-1:0] sv_exp, input logic err,
                            input logic [31:0] rd, input int lat, input bit keep);
      resp_t r;
      sreq_t s;
      int    acc;
      int    n;
      acc = (cyc == last_resp_cyc) ? cyc + 2 : cyc + 1;
      if (sv_exp != '0) begin
         s.mask  = sv_exp;
         s.addr  = a;
         s.wdata = wd;
         s.we    = we;
         sq.push_back(s);
      end
      r.err    = err;
      r.rdata  = rd;
      r.due    = acc + lat;
      r.addr   = a;
      r.we     = we;
      r.mapped = (sv_exp != '0);
      rq.push_back(r);
      m_addr  = a;
      m_wdata = wd;
      m_we    = we;
      m_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_ready !== 1'b1 && n < 300);
      if (m_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL access_timeout: no m_ready for addr 0x%08h within %0d cycles", a, n);
         m_valid = 1'b0;
         rst_n   = 1'b0;
         rq.delete();
         sq.delete();
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         return;
      end
      last_resp_cyc = cyc;
      if (!keep) m_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin : main
      int r1;
      int r2;
      for (int i = 0; i < NS; i++) ack_dly[i] = 1;

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_m_ready", 32'(m_ready), 32'h0);
      chk("rst_m_err", 32'(m_err), 32'h0);
      chk("rst_m_rdata", m_rdata, 32'h0);
      chk("rst_s_valid", 32'(s_valid), 32'h0);
      chk("rst_s_addr", s_addr, 32'h0);
      chk("rst_s_wdata", s_wdata, 32'h0);
      chk("rst_s_we", 32'(s_we), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write to Ed25519 window, 1-cycle ack
      do_access(32'h4000_1008, 32'h1234_5678, 1'b1, 4'b0010, 1'b0, 32'h0, 2, 1'b0);
      @(negedge clk);

      // Read from RSA window
      s_rdata[96 +: 32] = 32'hCAFE_0001;
      do_access(32'h4000_3100, 32'h0, 1'b0, 4'b1000, 1'b0, 32'hCAFE_0001, 2, 1'b0);
      @(negedge clk);

      // Unmapped: far away, just above the region, just below it
      do_access(32'h5000_0000, 32'h0, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
      @(negedge clk);
      do_access(32'h4000_4000, 32'h55AA_55AA, 1'b1, 4'b0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
      @(negedge clk);
      do_access(32'h3FFF_FFFC, 32'h0, 1'b0, 4'b0000, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
      @(negedge clk);

      // Slow slot 3 (3-cycle ack) with a stray ready from slot 0 during WAIT
      ack_dly[3] = 3;
      s_rdata[96 +: 32] = 32'hC0FF_EE03;
      inj_mask   = 4'b0001;
      inj_at_cyc = cyc + 3;
      do_access(32'h4000_3FFC, 32'h0, 1'b0, 4'b1000, 1'b0, 32'hC0FF_EE03, 4, 1'b0);
      ack_dly[3] = 1;
      @(negedge clk);

`ifdef CRYPTO_XBAR_TIMEOUT_EN
      // Slot 2 never acks: error after TMO cycles in WAIT, late ready ignored
      ack_dly[2] = 0;
      do_access(32'h4000_2010, 32'h0, 1'b0, 4'b0100, 1'b1, 32'hDEAD_BEEF, TMO + 1, 1'b0);
      inj_mask   = 4'b0100;
      inj_at_cyc = cyc + 3;
      repeat (8) @(negedge clk);
      ack_dly[2] = 1;
`endif

      // Reset while waiting on a silent slave: no response for that access
      begin
         sreq_t s;
         ack_dly[2] = 0;
         s.mask  = 4'b0100;
         s.addr  = 32'h4000_2004;
         s.wdata = 32'h0BAD_F00D;
         s.we    = 1'b1;
         sq.push_back(s);
         m_addr  = 32'h4000_2004;
         m_wdata = 32'h0BAD_F00D;
         m_we    = 1'b1;
         m_valid = 1'b1;
         repeat (3) @(negedge clk);
         rst_n   = 1'b0;
         m_valid = 1'b0;
         @(negedge clk);
         chk("midrst_m_ready", 32'(m_ready), 32'h0);
         chk("midrst_s_valid", 32'(s_valid), 32'h0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         ack_dly[2] = 1;
         @(negedge clk);
      end
      do_access(32'h4000_0000, 32'hA5A5_0000, 1'b1, 4'b0001, 1'b0, 32'h0, 2, 1'b0);
      @(negedge clk);

      // Back-to-back reads to slots 0 and 1 with m_valid held
      s_rdata[0 +: 32]  = 32'hA0A0_0000;
      s_rdata[32 +: 32] = 32'hB1B1_0001;
      do_access(32'h4000_0000, 32'h0, 1'b0, 4'b0001, 1'b0, 32'hA0A0_0000, 2, 1'b1);
      r1 = last_resp_cyc;
      do_access(32'h4000_1004, 32'h0, 1'b0, 4'b0010, 1'b0, 32'hB1B1_0001, 2, 1'b0);
      r2 = last_resp_cyc;
      chk("b2b_spacing", 32'(r2 - r1), 32'd4);

      repeat (4) @(negedge clk);
      chk("resp_queue_empty", 32'(rq.size()), 32'h0);
      chk("sreq_queue_empty", 32'(sq.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
